// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI slave-select arbiter: slave codes, arbiter states
// and the slave-code validity check.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        SS_NONE = 3'd0,
        SS_CH1  = 3'd1,
        SS_CH2  = 3'd2,
        SS_CH3  = 3'd3,
        SS_TRIG = 3'd4,
        SS_EEP  = 3'd5
    } ss_code_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LAUNCH   = 3'd1,
        ST_BUSY     = 3'd2,
        ST_RESP_ERR = 3'd3,
        ST_GAP      = 3'd4
    } arb_state_t;

    // Codes 0, 6 and 7 address no board-level slave.
    function automatic logic is_valid_ss(input logic [2:0] code);
        return (code >= 3'd1) && (code <= 3'd5);
    endfunction

endpackage

// File: rtl/spi_ss_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping. Generic so other shared-peripheral arbiters can reuse it.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Scan from the farthest offset back to ptr_i so the nearest hit wins last.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand_s  = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
            hit_s   = req_i[cand_s];
            idx_o   = hit_s ? cand_s : idx_o;
            valid_o = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/spi_ss_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters, with
// slave-select fan-out. Define SPI_ARB_TIMEOUT_EN to build the BUSY watchdog.
module spi_ss_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int DATA_W      = 16,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [3*NUM_REQ-1:0]  req_ss,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic                  err,
    output logic [DATA_W-1:0]     rd_data,
    output logic [DATA_W-1:0]     spi_cmd,
    output logic                  spi_wrt,
    input  logic                  spi_ss_n,
    input  logic [DATA_W-1:0]     spi_rdata,
    input  logic                  spi_done,
    output logic                  ch1_ss_n,
    output logic                  ch2_ss_n,
    output logic                  ch3_ss_n,
    output logic                  trig_ss_n,
    output logic                  EEP_ss_n
);

    localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t          state_q,   state_d;
    logic [IDX_W-1:0]    rr_ptr_q,  rr_ptr_d;
    logic [IDX_W-1:0]    idx_q,     idx_d;
    logic [2:0]          cur_ss_q,  cur_ss_d;
    logic [DATA_W-1:0]   spi_cmd_q, spi_cmd_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                err_q,     err_d;
    logic [NUM_REQ-1:0]  gnt_q,     gnt_d;
    logic [NUM_REQ-1:0]  done_q,    done_d;
    logic                spi_wrt_q, spi_wrt_d;
    logic [3:0]          gap_cnt_q, gap_cnt_d;

    logic [IDX_W-1:0]    pick_idx_s;
    logic                pick_valid_s;
    logic [2:0]          sel_ss_s;
    logic [DATA_W-1:0]   sel_data_s;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int              WDOG_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT_CYC);
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    assign sel_ss_s   = req_ss[int'(pick_idx_s) * 3 +: 3];
    assign sel_data_s = req_data[int'(pick_idx_s) * DATA_W +: DATA_W];

    // Next-state and registered-output computation for the arbiter FSM.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        idx_d     = idx_q;
        cur_ss_d  = cur_ss_q;
        spi_cmd_d = spi_cmd_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;
        gnt_d     = '0;
        done_d    = '0;
        spi_wrt_d = 1'b0;
        gap_cnt_d = gap_cnt_q;
`ifdef SPI_ARB_TIMEOUT_EN
        wdog_d    = wdog_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    gnt_d[pick_idx_s] = 1'b1;
                    idx_d     = pick_idx_s;
                    cur_ss_d  = sel_ss_s;
                    spi_cmd_d = sel_data_s;
                    rr_ptr_d  = (pick_idx_s == LAST_IDX) ? '0 : pick_idx_s + IDX_W'(1);
                    state_d   = is_valid_ss(sel_ss_s) ? ST_LAUNCH : ST_RESP_ERR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                spi_wrt_d = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                wdog_d    = '0;
`endif
                state_d   = ST_BUSY;
            end
            ST_BUSY: begin
                if (spi_done) begin
                    rd_data_d      = spi_rdata;
                    done_d[idx_q]  = 1'b1;
                    err_d          = 1'b0;
                    gap_cnt_d      = 4'd0;
                    state_d        = ST_GAP;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                // Watchdog expiry: abort with error and drop the select at once.
                else if (wdog_q == WDOG_LAST) begin
                    done_d[idx_q]  = 1'b1;
                    err_d          = 1'b1;
                    cur_ss_d       = SS_NONE;
                    gap_cnt_d      = 4'd0;
                    state_d        = ST_GAP;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
`else
                else begin
                    state_d = ST_BUSY;
                end
`endif
            end
            ST_RESP_ERR: begin
                done_d[idx_q] = 1'b1;
                err_d         = 1'b1;
                gap_cnt_d     = 4'd0;
                state_d       = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'(GAP_CYC - 1)) begin
                    cur_ss_d = SS_NONE;
                    state_d  = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                cur_ss_d = SS_NONE;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            idx_q     <= '0;
            cur_ss_q  <= SS_NONE;
            spi_cmd_q <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            gnt_q     <= '0;
            done_q    <= '0;
            spi_wrt_q <= 1'b0;
            gap_cnt_q <= 4'd0;
`ifdef SPI_ARB_TIMEOUT_EN
            wdog_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            idx_q     <= idx_d;
            cur_ss_q  <= cur_ss_d;
            spi_cmd_q <= spi_cmd_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            spi_wrt_q <= spi_wrt_d;
            gap_cnt_q <= gap_cnt_d;
`ifdef SPI_ARB_TIMEOUT_EN
            wdog_q    <= wdog_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rd_data = rd_data_q;
    assign spi_cmd = spi_cmd_q;
    assign spi_wrt = spi_wrt_q;

    // Decode is combinational off cur_ss_q so an async reset releases selects immediately.
    assign ch1_ss_n  = (cur_ss_q == SS_CH1)  ? spi_ss_n : 1'b1;
    assign ch2_ss_n  = (cur_ss_q == SS_CH2)  ? spi_ss_n : 1'b1;
    assign ch3_ss_n  = (cur_ss_q == SS_CH3)  ? spi_ss_n : 1'b1;
    assign trig_ss_n = (cur_ss_q == SS_TRIG) ? spi_ss_n : 1'b1;
    assign EEP_ss_n  = (cur_ss_q == SS_EEP)  ? spi_ss_n : 1'b1;

endmodule

// File: tb/tb_spi_ss_arbiter.sv
// Self-checking bench for spi_ss_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin model.
module tb_spi_ss_arbiter;

    localparam int NUM = 3;
    localparam int DW  = 16;
    localparam int GAP = 4;
    localparam int TMO = 1024;

    logic              clk;
    logic              rst_n;
    logic [NUM-1:0]    req;
    logic [3*NUM-1:0]  req_ss;
    logic [DW*NUM-1:0] req_data;
    logic [NUM-1:0]    gnt;
    logic [NUM-1:0]    done;
    logic              err;
    logic [DW-1:0]     rd_data;
    logic [DW-1:0]     spi_cmd;
    logic              spi_wrt;
    logic              spi_ss_n;
    logic [DW-1:0]     spi_rdata;
    logic              spi_done;
    logic              ch1_ss_n, ch2_ss_n, ch3_ss_n, trig_ss_n, EEP_ss_n;
    logic [4:0]        sel_v;

    int          errors = 0;
    int          checks = 0;
    bit          spi_auto = 1'b0;
    logic [DW-1:0] served_word = '0;

    assign sel_v = {EEP_ss_n, trig_ss_n, ch3_ss_n, ch2_ss_n, ch1_ss_n};

    spi_ss_arbiter #(
        .NUM_REQ(NUM), .DATA_W(DW), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_ss(req_ss), .req_data(req_data),
        .gnt(gnt), .done(done), .err(err), .rd_data(rd_data), .spi_cmd(spi_cmd),
        .spi_wrt(spi_wrt), .spi_ss_n(spi_ss_n), .spi_rdata(spi_rdata),
        .spi_done(spi_done), .ch1_ss_n(ch1_ss_n), .ch2_ss_n(ch2_ss_n),
        .ch3_ss_n(ch3_ss_n), .trig_ss_n(trig_ss_n), .EEP_ss_n(EEP_ss_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int oh_idx(input logic [NUM-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NUM; i++)
            if (v === (NUM'(1) << i)) r = i;
        return r;
    endfunction

    // Behavioural SPI master: answers each launch after a random latency.
    task automatic spi_responder();
        forever begin
            @(posedge clk); #1;
            if (spi_auto && spi_wrt === 1'b1) begin
                spi_ss_n = 1'b0;
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
                served_word = DW'($urandom);
                spi_rdata   = served_word;
                spi_done    = 1'b1;
                @(posedge clk); #1;
                spi_done = 1'b0;
                spi_ss_n = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; req_ss = '0; req_data = '0;
        spi_ss_n = 1'b1; spi_rdata = '0; spi_done = 1'b0; spi_auto = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++;
        if (gnt !== 3'b000 || done !== 3'b000 || err !== 1'b0 || spi_wrt !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: gnt=%b done=%b err=%b wrt=%b, required all 0", gnt, done, err, spi_wrt);
        end
        checks++;
        if (rd_data !== 16'h0000 || spi_cmd !== 16'h0000) begin
            errors++; $display("FAIL reset_data: rd_data=%h spi_cmd=%h, required 0000", rd_data, spi_cmd);
        end
        checks++;
        if (sel_v !== 5'b11111) begin
            errors++; $display("FAIL reset_sel: %b, required 11111", sel_v);
        end
    endtask

    task automatic test_single();
        req_ss[2:0] = 3'd2; req_data[15:0] = 16'hA5C3; req[0] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 3'b001 || spi_wrt !== 1'b0) begin
            errors++; $display("FAIL single_gnt: gnt=%b wrt=%b, required 001/0", gnt, spi_wrt);
        end
        req[0] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (spi_wrt !== 1'b1 || spi_cmd !== 16'hA5C3) begin
            errors++; $display("FAIL single_launch: wrt=%b cmd=%h, required 1/a5c3", spi_wrt, spi_cmd);
        end
        spi_ss_n = 1'b0; #1;
        checks++;
        if (sel_v !== 5'b11101) begin
            errors++; $display("FAIL single_sel: %b, required 11101", sel_v);
        end
        @(posedge clk); #1;
        checks++;
        if (spi_wrt !== 1'b0) begin
            errors++; $display("FAIL single_wrt_once: wrt=%b, required 0", spi_wrt);
        end
        repeat (2) @(posedge clk); #1;
        checks++;
        if (done !== 3'b000) begin
            errors++; $display("FAIL single_early_done: done=%b, required 000", done);
        end
        spi_rdata = 16'h1234; spi_done = 1'b1;
        @(posedge clk); #1;
        spi_done = 1'b0; spi_ss_n = 1'b1; spi_rdata = '0;
        checks++;
        if (done !== 3'b001 || err !== 1'b0 || rd_data !== 16'h1234) begin
            errors++; $display("FAIL single_done: done=%b err=%b rd=%h, required 001/0/1234", done, err, rd_data);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 3'b000 || rd_data !== 16'h1234) begin
            errors++; $display("FAIL single_done_pulse: done=%b rd=%h, required 000/1234", done, rd_data);
        end
        repeat (GAP + 2) @(posedge clk); #1;
    endtask

    task automatic test_invalid();
        req_ss[5:3] = 3'd7; req_data[31:16] = 16'hBEEF; spi_ss_n = 1'b0; req[1] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 3'b010) begin
            errors++; $display("FAIL inv_gnt: gnt=%b, required 010", gnt);
        end
        req[1] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 3'b010 || err !== 1'b1 || rd_data !== 16'h1234 || spi_wrt !== 1'b0) begin
            errors++; $display("FAIL inv_done: done=%b err=%b rd=%h wrt=%b, required 010/1/1234/0", done, err, rd_data, spi_wrt);
        end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            checks++;
            if (spi_wrt !== 1'b0 || sel_v !== 5'b11111 || done !== 3'b000) begin
                errors++; $display("FAIL inv_quiet: cyc %0d wrt=%b sel=%b done=%b, required 0/11111/000", c, spi_wrt, sel_v, done);
            end
        end
        spi_ss_n = 1'b1;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL inv_err_hold: err=%b, required 1", err);
        end
    endtask

    task automatic test_reset_mid_busy();
        req_ss[8:6] = 3'd5; req_data[47:32] = 16'h5A5A; req[2] = 1'b1;
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(posedge clk); #1;
        spi_ss_n = 1'b0; #1;
        checks++;
        if (sel_v !== 5'b01111) begin
            errors++; $display("FAIL rst_busy_eep: sel=%b, required 01111", sel_v);
        end
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        checks++;
        if (sel_v !== 5'b11111) begin
            errors++; $display("FAIL rst_busy_sel: sel=%b, required 11111", sel_v);
        end
        checks++;
        if (rd_data !== 16'h0000 || spi_cmd !== 16'h0000 || err !== 1'b0 || done !== 3'b000) begin
            errors++; $display("FAIL rst_busy_vals: rd=%h cmd=%h err=%b done=%b, required 0", rd_data, spi_cmd, err, done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; spi_ss_n = 1'b1;
        @(posedge clk); #1;
        spi_rdata = 16'hFFFF; spi_done = 1'b1;
        @(posedge clk); #1;
        spi_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (done !== 3'b000 || rd_data !== 16'h0000 || spi_wrt !== 1'b0 || gnt !== 3'b000) begin
                errors++; $display("FAIL rst_busy_nodone: done=%b rd=%h wrt=%b gnt=%b, required 0", done, rd_data, spi_wrt, gnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stray_done();
        spi_rdata = 16'hDEAD; spi_done = 1'b1;
        @(posedge clk); #1;
        spi_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (done !== 3'b000 || rd_data !== 16'h0000) begin
                errors++; $display("FAIL stray_ignored: done=%b rd=%h, required 000/0000", done, rd_data);
            end
            @(posedge clk); #1;
        end
        req_ss[2:0] = 3'd3; req_data[15:0] = 16'h0F0F; req[0] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 3'b001) begin
            errors++; $display("FAIL stray_gnt: gnt=%b, required 001", gnt);
        end
        req[0] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (spi_wrt !== 1'b1 || spi_cmd !== 16'h0F0F) begin
            errors++; $display("FAIL stray_launch: wrt=%b cmd=%h, required 1/0f0f", spi_wrt, spi_cmd);
        end
        spi_ss_n = 1'b0; #1;
        checks++;
        if (sel_v !== 5'b11011) begin
            errors++; $display("FAIL stray_sel: sel=%b, required 11011", sel_v);
        end
        @(posedge clk); #1;
        spi_rdata = 16'h7E81; spi_done = 1'b1;
        @(posedge clk); #1;
        spi_done = 1'b0; spi_ss_n = 1'b1;
        checks++;
        if (done !== 3'b001 || err !== 1'b0 || rd_data !== 16'h7E81) begin
            errors++; $display("FAIL stray_done: done=%b err=%b rd=%h, required 001/0/7e81", done, err, rd_data);
        end
        repeat (GAP + 2) @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int k;
        req_ss[5:3] = 3'd1; req_data[31:16] = 16'h1111; req[1] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 3'b010) begin
            errors++; $display("FAIL tmo_gnt: gnt=%b, required 010", gnt);
        end
        req[1] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (spi_wrt !== 1'b1) begin
            errors++; $display("FAIL tmo_launch: wrt=%b, required 1", spi_wrt);
        end
        spi_ss_n = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        k = 0;
        while (k <= TMO + 8) begin
            @(posedge clk); #1;
            k++;
            if (done !== 3'b000) break;
        end
        checks++;
        if (done !== 3'b010 || k != TMO || err !== 1'b1 || rd_data !== 16'h7E81) begin
            errors++; $display("FAIL tmo_done: done=%b after %0d cyc err=%b rd=%h, required 010 after %0d/1/7e81", done, k, err, rd_data, TMO);
        end
        checks++;
        if (sel_v !== 5'b11111) begin
            errors++; $display("FAIL tmo_sel: sel=%b, required 11111", sel_v);
        end
        spi_rdata = 16'hAAAA; spi_done = 1'b1;
        @(posedge clk); #1;
        spi_done = 1'b0; spi_ss_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (done !== 3'b000 || rd_data !== 16'h7E81) begin
                errors++; $display("FAIL tmo_late: done=%b rd=%h, required 000/7e81", done, rd_data);
            end
            @(posedge clk); #1;
        end
`else
        for (k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 3'b000 || ch1_ss_n !== 1'b0) begin
                errors++; $display("FAIL busy_hold: cyc %0d done=%b ch1=%b, required 000/0", k, done, ch1_ss_n);
            end
        end
        spi_rdata = 16'hAAAA; spi_done = 1'b1;
        @(posedge clk); #1;
        spi_done = 1'b0; spi_ss_n = 1'b1;
        checks++;
        if (done !== 3'b010 || err !== 1'b0 || rd_data !== 16'hAAAA) begin
            errors++; $display("FAIL busy_done: done=%b err=%b rd=%h, required 010/0/aaaa", done, err, rd_data);
        end
`endif
        repeat (GAP + 2) @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int order[4];
        int n, last_done, cyc, gi;
        bit seen;
        do_reset();
        spi_auto = 1'b1;
        req_ss   = {3'd5, 3'd4, 3'd1};
        req_data = {16'hC0DE, 16'hB0B0, 16'hA0A0};
        req      = 3'b111;
        n = 0; last_done = -100;
        for (cyc = 0; cyc < 400 && n < 4; cyc++) begin
            @(posedge clk); #3;
            if (done !== 3'b000) last_done = cyc;
            if (gnt !== 3'b000) begin
                gi = oh_idx(gnt);
                order[n] = gi;
                n++;
                checks++;
                if (n > 1 && cyc - last_done < GAP + 1) begin
                    errors++; $display("FAIL rr_gap: gnt %0d only %0d cyc after done, required >= %0d", n, cyc - last_done, GAP + 1);
                end
            end
        end
        req = '0;
        checks++;
        if (n != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 0) begin
            errors++; $display("FAIL rr_order: %0d grants %0d,%0d,%0d,%0d, required 0,1,2,0", n, order[0], order[1], order[2], order[3]);
        end
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge clk); #3;
            if (done === 3'b001) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rr_last_done: no done[0] within 50 cycles, required one");
        end
        spi_auto = 1'b0;
        repeat (GAP + 8) @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit            pend[NUM];
        logic [2:0]    code[NUM];
        logic [DW-1:0] word[NUM];
        int            last_done_of[NUM];
        int            owner, exp_ptr, exp_w, gi, gcyc, last_done, served, cyc;
        bit            own_valid, wrt_seen;
        logic [DW-1:0] model_rd;
        logic [4:0]    exp_sel;
        do_reset();
        spi_auto = 1'b1;
        owner = -1; exp_ptr = 0; last_done = -100; served = 0; gcyc = 0;
        own_valid = 1'b0; wrt_seen = 1'b0; model_rd = '0;
        for (int i = 0; i < NUM; i++) begin
            pend[i] = 1'b0; last_done_of[i] = -1; code[i] = '0; word[i] = '0;
        end
        for (cyc = 0; cyc < 3000 && served < 40; cyc++) begin
            @(posedge clk); #3;
            if (gnt !== 3'b000) begin
                exp_w = -1;
                for (int k = NUM - 1; k >= 0; k--)
                    if (pend[(exp_ptr + k) % NUM]) exp_w = (exp_ptr + k) % NUM;
                gi = oh_idx(gnt);
                checks++;
                if (gi != exp_w || owner != -1 || cyc - last_done < GAP + 1) begin
                    errors++; $display("FAIL rand_gnt: gnt=%b owner=%0d gap=%0d, required idx %0d, idle, gap >= %0d", gnt, owner, cyc - last_done, exp_w, GAP + 1);
                end
                if (gi >= 0) begin
                    owner = gi; exp_ptr = (gi + 1) % NUM; pend[gi] = 1'b0; req[gi] = 1'b0;
                    gcyc = cyc; own_valid = (code[gi] inside {[3'd1:3'd5]}); wrt_seen = 1'b0;
                end
            end
            if (spi_wrt === 1'b1) begin
                checks++;
                if (owner < 0) begin
                    errors++; $display("FAIL rand_wrt: launch with no owner, required none");
                end else if (!own_valid || wrt_seen || cyc != gcyc + 1 || spi_cmd !== word[owner]) begin
                    errors++; $display("FAIL rand_wrt: code=%0d cyc=%0d cmd=%h, required valid code, cyc %0d, cmd %h", code[owner], cyc, spi_cmd, gcyc + 1, word[owner]);
                end
                wrt_seen = 1'b1;
            end
            if (done !== 3'b000) begin
                checks++;
                if (owner < 0) begin
                    errors++; $display("FAIL rand_done: done=%b with no owner, required 000", done);
                end else begin
                    if (own_valid) model_rd = served_word;
                    if (done !== (NUM'(1) << owner) || err !== !own_valid || rd_data !== model_rd || wrt_seen != own_valid) begin
                        errors++; $display("FAIL rand_done: done=%b err=%b rd=%h wrt=%b, required %b/%b/%h/%b", done, err, rd_data, wrt_seen, NUM'(1) << owner, !own_valid, model_rd, own_valid);
                    end
                    last_done_of[owner] = cyc; owner = -1; last_done = cyc; served++;
                end
            end
            if (spi_ss_n === 1'b0 && owner >= 0) begin
                exp_sel = 5'b11111;
                if (code[owner] inside {[3'd1:3'd5]}) exp_sel[int'(code[owner]) - 1] = 1'b0;
                checks++;
                if (sel_v !== exp_sel) begin
                    errors++; $display("FAIL rand_sel: sel=%b, required %b", sel_v, exp_sel);
                end
            end
            for (int i = 0; i < NUM; i++) begin
                if (!pend[i] && owner != i && cyc > last_done_of[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    code[i] = 3'($urandom_range(0, 7));
                    word[i] = DW'($urandom);
                    req_ss[i*3 +: 3]    = code[i];
                    req_data[i*DW +: DW] = word[i];
                    req[i] = 1'b1;
                end
            end
        end
        req = '0;
        checks++;
        if (served < 40) begin
            errors++; $display("FAIL rand_liveness: %0d transactions served, required 40", served);
        end
        repeat (GAP + 10) @(posedge clk); #1;
        spi_auto = 1'b0;
    endtask

    initial begin
        fork
            spi_responder();
        join_none
        do_reset();
        test_reset();
        test_single();
        test_invalid();
        test_reset_mid_busy();
        test_stray_done();
        test_timeout();
        test_round_robin();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "bench timeout");
    end

endmodule
